fetch_ifu: RTL and testbench

//  Instruction-fetch stage of the RV64 ready/valid pipeline; sits directly upstream of the D-stage register.

---
 rtl/fetch_ifu.sv | 114 +++++++++++
 tb/tb_fetch_ifu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifu.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests,
// pairs each response with its PC and queues {pc,instr} toward decode; redirects squash wrong-path fetches.
module fetch_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_o_valid,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  input  logic        fetch_i_ready
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [63:0]            pc_q, pc_d;
  logic [DEPTH-1:0][63:0] ifq_q, ifq_d;
  logic [AW-1:0]          if_wp_q, if_wp_d, if_rp_q, if_rp_d;
  logic [AW:0]            inflight_q, inflight_d;
  fetch_ent_t [DEPTH-1:0] oq_q, oq_d;
  logic [AW-1:0]          oq_wp_q, oq_wp_d, oq_rp_q, oq_rp_d;
  logic [AW:0]            q_count_q, q_count_d;
  logic [AW:0]            drop_q, drop_d;
  logic                   req_fire, rsp_fire, out_fire, keep;

  // One credit per request in flight or entry queued, so responses always have room.
  assign imem_req_valid = ~rst & (({1'b0, inflight_q} + {1'b0, q_count_q}) < DEPTH_L);
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = 1'b1;
  assign fetch_o_valid  = (q_count_q != '0);
  assign fetch_o_pc     = fetch_o_valid ? oq_q[oq_rp_q].pc    : '0;
  assign fetch_o_instr  = fetch_o_valid ? oq_q[oq_rp_q].instr : '0;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (inflight_q != '0);
  assign out_fire = fetch_o_valid & fetch_i_ready;
  assign keep     = rsp_fire & (drop_q == '0) & ~redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    ifq_d      = ifq_q;
    if_wp_d    = if_wp_q;
    if_rp_d    = if_rp_q;
    oq_d       = oq_q;
    oq_wp_d    = oq_wp_q;
    oq_rp_d    = oq_rp_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + (AW+1)'(req_fire) - (AW+1)'(rsp_fire);
    q_count_d  = q_count_q + (AW+1)'(keep) - (AW+1)'(out_fire);
    if (req_fire) begin
      ifq_d[if_wp_q] = pc_q;
      if_wp_d        = if_wp_q + AW'(1);
      pc_d           = pc_q + 64'd4;
    end
    if (rsp_fire) begin
      if_rp_d = if_rp_q + AW'(1);
      if (drop_q != '0) drop_d = drop_q - (AW+1)'(1);
    end
    if (keep) begin
      oq_d[oq_wp_q].pc    = ifq_q[if_rp_q];
      oq_d[oq_wp_q].instr = imem_rsp_data;
      oq_wp_d             = oq_wp_q + AW'(1);
    end
    if (out_fire) oq_rp_d = oq_rp_q + AW'(1);
    // Everything still in flight after this cycle's events is wrong-path.
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~64'h3;
      oq_wp_d   = '0;
      oq_rp_d   = '0;
      q_count_d = '0;
      drop_d    = inflight_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ifq_q      <= '0;
      if_wp_q    <= '0;
      if_rp_q    <= '0;
      inflight_q <= '0;
      oq_q       <= '0;
      oq_wp_q    <= '0;
      oq_rp_q    <= '0;
      q_count_q  <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      ifq_q      <= ifq_d;
      if_wp_q    <= if_wp_d;
      if_rp_q    <= if_rp_d;
      inflight_q <= inflight_d;
      oq_q       <= oq_d;
      oq_wp_q    <= oq_wp_d;
      oq_rp_q    <= oq_rp_d;
      q_count_q  <= q_count_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_ifu.sv
// Bench for fetch_ifu: imem model with random latency, program-order stream model,
// table-driven start-up/stall vectors and hand sequences for redirect and wrap corners.
module tb_fetch_ifu;
  localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0, imem_rsp_ready;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_o_valid;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic        fetch_i_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_ifu #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_o_valid(fetch_o_valid), .fetch_o_pc(fetch_o_pc), .fetch_o_instr(fetch_o_instr),
    .fetch_i_ready(fetch_i_ready)
  );

  int n_checks = 0, n_fail = 0, delivered = 0, rsp_pct = 100;
  logic [63:0] pend[$];
  logic [63:0] exp_req = RPC, exp_fo = RPC, prev_addr = '0, d_rpc = '0;
  logic        prev_hold = 1'b0, d_rr = 1'b0, d_fr = 1'b0, d_redir = 1'b0;
  logic        s_rv, s_fv, s_rspv;
  logic [63:0] s_ra, s_fpc;
  logic [31:0] s_fin;

  typedef struct {
    logic rr; logic fr; logic ev; logic [63:0] ea; logic fv; logic [63:0] fpc;
  } vec_t;
  vec_t vt[21];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
  endfunction

  function automatic vec_t mk(input logic rr, input logic fr, input logic ev, input int ai,
                              input logic fv, input int fi);
    vec_t v;
    v.rr = rr; v.fr = fr; v.ev = ev; v.fv = fv;
    v.ea  = RPC + 64'(4 * ai);
    v.fpc = fv ? RPC + 64'(4 * fi) : 64'h0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ev);
    n_checks++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, ev);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, update the stream model, then cross the posedge.
  task automatic cycle();
    @(negedge clk);
    imem_req_ready = d_rr; fetch_i_ready = d_fr;
    redirect_valid = d_redir; redirect_pc = d_rpc;
    if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_rspv = imem_rsp_valid;
    s_fv = fetch_o_valid; s_fpc = fetch_o_pc; s_fin = fetch_o_instr;
    chk("rsp_ready", imem_rsp_ready, 1);
    if (prev_hold) begin
      chk("hold_valid", s_rv, 1);
      chk("hold_addr", s_ra, prev_addr);
    end
    if (s_fv) begin
      chk("fo_pc", s_fpc, exp_fo);
      chk("fo_instr", s_fin, mem_word(exp_fo));
    end else begin
      chk("fo_pc_idle", s_fpc, 0);
      chk("fo_instr_idle", s_fin, 0);
    end
    if (s_rv && d_rr) begin
      chk("req_addr", s_ra, exp_req);
      pend.push_back(s_ra);
      exp_req += 64'd4;
    end
    if (s_rspv) void'(pend.pop_front());
    if (s_fv && d_fr) begin exp_fo += 64'd4; delivered++; end
    prev_hold = s_rv && !d_rr && !d_redir;
    prev_addr = s_ra;
    if (d_redir) begin exp_req = d_rpc & ~64'h3; exp_fo = exp_req; end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    d_redir = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_fo_valid", fetch_o_valid, 0);
    chk("rst_fo_pc", fetch_o_pc, 0);
    chk("rst_fo_instr", fetch_o_instr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    exp_req = RPC; exp_fo = RPC; prev_hold = 1'b0;
  endtask

  task automatic wait_fo(input string nm, input logic [63:0] pc, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (s_fv) seen = 1'b1;
    end
    if (seen) chk(nm, s_fpc, pc);
    else begin
      n_checks++; n_fail++;
      $display("FAIL %s: no fetch_o_valid within %0d cycles, expected pc %h", nm, budget, pc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start-up at one instr/cycle, then a 10-cycle decode stall filling all credits, then resume.
    for (int k = 0; k < 6; k++) vt[k] = mk(1, 1, 1, k, k >= 2, k - 2);
    vt[6] = mk(1, 0, 1, 6, 1, 4);
    vt[7] = mk(1, 0, 1, 7, 1, 4);
    for (int k = 8; k < 16; k++) vt[k] = mk(1, 0, 0, 8, 1, 4);
    vt[16] = mk(1, 1, 0, 8, 1, 4);
    vt[17] = mk(1, 1, 1, 8, 1, 5);
    vt[18] = mk(1, 1, 1, 9, 1, 6);
    vt[19] = mk(1, 1, 1, 10, 1, 7);
    vt[20] = mk(1, 1, 1, 11, 1, 8);

    do_reset();
    rsp_pct = 100;
    for (int k = 0; k < 21; k++) begin
      d_rr = vt[k].rr; d_fr = vt[k].fr;
      cycle();
      chk($sformatf("tbl%0d_req_valid", k), s_rv, vt[k].ev);
      chk($sformatf("tbl%0d_req_addr", k), s_ra, vt[k].ea);
      chk($sformatf("tbl%0d_fo_valid", k), s_fv, vt[k].fv);
      chk($sformatf("tbl%0d_fo_pc", k), s_fpc, vt[k].fpc);
      chk($sformatf("tbl%0d_fo_instr", k), s_fin, vt[k].fv ? mem_word(vt[k].fpc) : 32'h0);
    end

    // Two requests in flight, redirect before either responds.
    do_reset();
    rsp_pct = 0; d_fr = 1; d_rr = 1;
    cycle(); cycle();
    d_rr = 0; d_redir = 1; d_rpc = 64'h1000;
    cycle();
    d_redir = 0; d_rr = 1; rsp_pct = 100;
    cycle();
    chk("t3_addr", s_ra, 64'h1000);
    chk("t3_no_fo", s_fv, 0);
    wait_fo("t3_first_pc", 64'h1000, 20);

    // Redirect in the same cycle as a request accept and a response.
    do_reset();
    rsp_pct = 100; d_rr = 1; d_fr = 1;
    cycle();
    d_redir = 1; d_rpc = 64'h2000;
    cycle();
    chk("t4_req_acc", s_rv, 1);
    chk("t4_rsp_same", s_rspv, 1);
    d_redir = 0;
    cycle();
    chk("t4_next_addr", s_ra, 64'h2000);
    chk("t4_no_fo", s_fv, 0);
    cycle();
    chk("t4_no_fo2", s_fv, 0);
    wait_fo("t4_first_pc", 64'h2000, 10);

    // imem back-pressure: request held stable, redirect retargets it.
    do_reset();
    rsp_pct = 100; d_fr = 1; d_rr = 0;
    for (int i = 0; i < 5; i++) begin
      d_redir = (i == 2); d_rpc = 64'h3000;
      cycle();
      chk($sformatf("t5_valid%0d", i), s_rv, 1);
      chk($sformatf("t5_addr%0d", i), s_ra, (i <= 2) ? RPC : 64'h3000);
    end
    d_redir = 0; d_rr = 1;
    wait_fo("t5_first_pc", 64'h3000, 10);

    // PC wrap, redirect alignment, async reset mid-burst.
    do_reset();
    rsp_pct = 100; d_rr = 1; d_fr = 1;
    d_redir = 1; d_rpc = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle();
    d_redir = 0;
    cycle();
    chk("t6_addr_top", s_ra, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    chk("t6_wrap", s_ra, 64'h0);
    d_redir = 1; d_rpc = 64'h1003;
    cycle();
    d_redir = 0;
    cycle();
    chk("t6_align", s_ra, 64'h1000);
    wait_fo("t6_first_pc", 64'h1000, 10);
    cycle(); cycle();
    chk("t6_pre_rst_fo", s_fv, 1);
    #2;
    do_reset();

    // Randomized traffic against the stream model.
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      d_rr = ($urandom_range(99) < 75);
      d_fr = ($urandom_range(99) < 70);
      rsp_pct = 60;
      d_redir = ($urandom_range(99) < 3);
      d_rpc = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                        : {32'($urandom), 32'($urandom)};
      cycle();
      if (i == 1500) begin #2; do_reset(); end
    end
    d_redir = 0;
    chk("rand_progress", delivered > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
